// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolve unit: compare-mode encodings,
// PHT counter states and the saturating counter update.
package branch_pkg;

  localparam logic [2:0] BR_EQ  = 3'd0;
  localparam logic [2:0] BR_NE  = 3'd1;
  localparam logic [2:0] BR_LEZ = 3'd2;
  localparam logic [2:0] BR_GTZ = 3'd3;
  localparam logic [2:0] BR_LTZ = 3'd4;
  localparam logic [2:0] BR_GEZ = 3'd5;

  typedef enum logic [1:0] {
    PhtStrongNt = 2'd0,
    PhtWeakNt   = 2'd1,
    PhtWeakT    = 2'd2,
    PhtStrongT  = 2'd3
  } pht_state_e;

  localparam logic [1:0] PHT_RESET = 2'b01;

  function automatic logic [1:0] pht_next(input logic [1:0] cnt, input logic taken);
    if (taken) begin
      return (cnt == PhtStrongT) ? cnt : cnt + 2'd1;
    end
    return (cnt == PhtStrongNt) ? cnt : cnt - 2'd1;
  endfunction

endpackage

// File: rtl/branch_cmp.sv
// Combinational branch compare: six modes on two WIDTH-bit operands.
// Zero compares treat d1 as signed; ops 6 and 7 flag illegal and report not-taken.
module branch_cmp
  import branch_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  output logic             taken,
  output logic             illegal
);

  logic is_zero;
  logic is_neg;

  assign is_zero = (d1 == '0);
  assign is_neg  = d1[WIDTH-1];

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (op)
      BR_EQ:   taken = (d1 == d2);
      BR_NE:   taken = (d1 != d2);
      BR_LEZ:  taken = is_neg | is_zero;
      BR_GTZ:  taken = ~is_neg & ~is_zero;
      BR_LTZ:  taken = is_neg;
      BR_GEZ:  taken = ~is_neg;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: registered compare decision plus a bimodal PHT of 2-bit counters.
// Optional resolve/mispredict statistics counters are enabled with BRANCH_STATS_EN.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned PHT_DEPTH = 64,
  parameter int unsigned IDX_LSB   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      pred_pc,
  output logic             pred_taken,
  input  logic             res_valid,
  input  logic [31:0]      res_pc,
  input  logic [2:0]       res_op,
  input  logic [WIDTH-1:0] res_d1,
  input  logic [WIDTH-1:0] res_d2,
  input  logic             res_pred,
  input  logic             stall,
  input  logic             flush,
`ifdef BRANCH_STATS_EN
  output logic [31:0]      stat_branches,
  output logic [31:0]      stat_mispredicts,
`endif
  output logic             out_valid,
  output logic             out_taken,
  output logic             out_mispredict
);

  localparam int unsigned IdxW = $clog2(PHT_DEPTH);

  logic [1:0]      pht_q [PHT_DEPTH];
  logic [IdxW-1:0] pred_idx;
  logic [IdxW-1:0] res_idx;
  logic            cmp_taken;
  logic            cmp_illegal;
  logic            accept;
  logic            out_valid_q;
  logic            out_taken_q;
  logic            out_mispredict_q;
  logic            unused_pc;

  // PC bits outside the index window are deliberately ignored (aliasing).
  assign unused_pc = ^{pred_pc, res_pc};

  assign pred_idx = pred_pc[IDX_LSB +: IdxW];
  assign res_idx  = res_pc[IDX_LSB +: IdxW];

  branch_cmp #(
    .WIDTH(WIDTH)
  ) u_cmp (
    .op     (res_op),
    .d1     (res_d1),
    .d2     (res_d2),
    .taken  (cmp_taken),
    .illegal(cmp_illegal)
  );

  assign accept = res_valid & ~stall & ~flush & ~cmp_illegal;

  // Read of the pre-update value gives the same-index collision behaviour for free.
  assign pred_taken = pht_q[pred_idx][1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < PHT_DEPTH; i++) begin
        pht_q[i] <= PHT_RESET;
      end
      out_valid_q      <= 1'b0;
      out_taken_q      <= 1'b0;
      out_mispredict_q <= 1'b0;
    end else begin
      out_valid_q <= accept;
      if (accept) begin
        out_taken_q      <= cmp_taken;
        out_mispredict_q <= cmp_taken ^ res_pred;
        pht_q[res_idx]   <= pht_next(pht_q[res_idx], cmp_taken);
      end
    end
  end

  assign out_valid      = out_valid_q;
  assign out_taken      = out_taken_q;
  assign out_mispredict = out_mispredict_q;

`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches_q;
  logic [31:0] stat_mispredicts_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
    end else if (accept) begin
      if (stat_branches_q != '1) begin
        stat_branches_q <= stat_branches_q + 32'd1;
      end
      if ((cmp_taken ^ res_pred) && (stat_mispredicts_q != '1)) begin
        stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
      end
    end
  end

  assign stat_branches    = stat_branches_q;
  assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed cases plus randomized resolves
// compared against an arithmetic reference model of the PHT and output registers.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic        res_valid;
  logic [31:0] res_pc;
  logic [2:0]  res_op;
  logic [31:0] res_d1;
  logic [31:0] res_d2;
  logic        res_pred;
  logic        stall;
  logic        flush;
  logic        out_valid;
  logic        out_taken;
  logic        out_mispredict;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state
  int mpht [64];
  bit mvalid, mtaken, mmis;
  longint mbr, mmp;

  always #5 clk = ~clk;

  branch_resolve_unit #(
    .WIDTH    (32),
    .PHT_DEPTH(64),
    .IDX_LSB  (2)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .pred_pc         (pred_pc),
    .pred_taken      (pred_taken),
    .res_valid       (res_valid),
    .res_pc          (res_pc),
    .res_op          (res_op),
    .res_d1          (res_d1),
    .res_d2          (res_d2),
    .res_pred        (res_pred),
    .stall           (stall),
    .flush           (flush),
`ifdef BRANCH_STATS_EN
    .stat_branches   (stat_branches),
    .stat_mispredicts(stat_mispredicts),
`endif
    .out_valid       (out_valid),
    .out_taken       (out_taken),
    .out_mispredict  (out_mispredict)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int idx(input logic [31:0] pc);
    return int'((pc / 4) % 64);
  endfunction

  function automatic bit ref_taken(input int op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      0: return a == b;
      1: return a != b;
      2: return $signed(a) <= 0;
      3: return $signed(a) > 0;
      4: return $signed(a) < 0;
      5: return $signed(a) >= 0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) mpht[i] = 1;
    mvalid = 0; mtaken = 0; mmis = 0; mbr = 0; mmp = 0;
  endtask

  task automatic check_stats(input string tag);
`ifdef BRANCH_STATS_EN
    check({tag, "_stat_br"}, stat_branches, 32'(mbr));
    check({tag, "_stat_mp"}, stat_mispredicts, 32'(mmp));
`else
    if (tag.len() < 0) check(tag, 32'd0, 32'd1);
`endif
  endtask

  // One clock of stimulus: checks prediction before the edge, outputs after it.
  task automatic step(input string tag, input logic [31:0] pc, input int op,
                      input logic [31:0] d1, input logic [31:0] d2, input bit pred,
                      input bit valid, input bit stl, input bit fl, input logic [31:0] ppc);
    bit acc, tk;
    res_valid = valid; res_pc = pc; res_op = op[2:0]; res_d1 = d1; res_d2 = d2;
    res_pred = pred; stall = stl; flush = fl; pred_pc = ppc;
    #1;
    check({tag, "_pred_pre"}, {31'd0, pred_taken}, {31'd0, mpht[idx(ppc)] >= 2});
    @(posedge clk);
    acc = valid && !stl && !fl && (op <= 5);
    tk  = ref_taken(op, d1, d2);
    if (acc) begin
      mtaken = tk;
      mmis   = tk ^ pred;
      mpht[idx(pc)] = tk ? ((mpht[idx(pc)] < 3) ? mpht[idx(pc)] + 1 : 3)
                         : ((mpht[idx(pc)] > 0) ? mpht[idx(pc)] - 1 : 0);
      if (mbr < 64'hFFFF_FFFF) mbr++;
      if (mmis && mmp < 64'hFFFF_FFFF) mmp++;
    end
    mvalid = acc;
    #1;
    check({tag, "_valid"}, {31'd0, out_valid}, {31'd0, mvalid});
    check({tag, "_taken"}, {31'd0, out_taken}, {31'd0, mtaken});
    check({tag, "_mis"}, {31'd0, out_mispredict}, {31'd0, mmis});
    check({tag, "_pred_post"}, {31'd0, pred_taken}, {31'd0, mpht[idx(ppc)] >= 2});
    check_stats(tag);
  endtask

  task automatic idle(input string tag, input logic [31:0] ppc);
    step(tag, 32'h0, 0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, ppc);
  endtask

  initial begin
    logic [31:0] pc, d1, d2, ppc;
    int op;
    bit stl, fl, vld, prd;

    reset = 1'b0; res_valid = 0; res_pc = 0; res_op = 0; res_d1 = 0; res_d2 = 0;
    res_pred = 0; stall = 0; flush = 0; pred_pc = 32'h3000;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_taken", {31'd0, out_taken}, 32'd0);
    check("rst_mis", {31'd0, out_mispredict}, 32'd0);
    check_stats("rst");
    for (int i = 0; i < 64; i++) begin
      pred_pc = 32'h3000 + 32'(i * 4);
      #0.1;
      check("rst_pht", {31'd0, pred_taken}, 32'd0);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;

    // BEQ taken with a not-taken prediction; same-index prediction sees the old value
    step("beq", 32'h3004, 0, 32'h1234, 32'h1234, 1'b0, 1, 0, 0, 32'h3004);
    check("beq_valid_d", {31'd0, out_valid}, 32'd1);
    check("beq_mis_d", {31'd0, out_mispredict}, 32'd1);
    check("beq_pred_d", {31'd0, pred_taken}, 32'd1);

    // Signed zero-compare edges
    step("gtz_min", 32'h3008, 3, 32'h8000_0000, 32'h0, 1'b0, 1, 0, 0, 32'h3008);
    check("gtz_min_t", {31'd0, out_taken}, 32'd0);
    step("lez_zero", 32'h3008, 2, 32'h0, 32'h0, 1'b0, 1, 0, 0, 32'h3008);
    check("lez_zero_t", {31'd0, out_taken}, 32'd1);
    step("gez_zero", 32'h300C, 5, 32'h0, 32'h0, 1'b1, 1, 0, 0, 32'h300C);
    check("gez_zero_t", {31'd0, out_taken}, 32'd1);

    // Saturation at 3 then at 0
    for (int i = 0; i < 3; i++) step("sat_up", 32'h3010, 1, 32'h1, 32'h2, 1'b1, 1, 0, 0, 32'h3010);
    for (int i = 0; i < 4; i++) step("sat_dn", 32'h3010, 0, 32'h1, 32'h2, 1'b1, 1, 0, 0, 32'h3010);
    check("sat_floor", {31'd0, pred_taken}, 32'd0);

    // Stall hold, flush over stall, illegal op
    step("stall0", 32'h3014, 4, 32'hFFFF_FFFF, 32'h0, 1'b0, 1, 1, 0, 32'h3014);
    step("stall1", 32'h3014, 4, 32'hFFFF_FFFF, 32'h0, 1'b0, 1, 1, 0, 32'h3014);
    step("stall_rel", 32'h3014, 4, 32'hFFFF_FFFF, 32'h0, 1'b0, 1, 0, 0, 32'h3014);
    idle("stall_after", 32'h3014);
    step("flush_stall", 32'h3018, 5, 32'h5, 32'h0, 1'b0, 1, 1, 1, 32'h3018);
    step("flush", 32'h3018, 5, 32'h5, 32'h0, 1'b0, 1, 0, 1, 32'h3018);
    step("illegal6", 32'h3018, 6, 32'h5, 32'h5, 1'b0, 1, 0, 0, 32'h3018);
    step("illegal7", 32'h3018, 7, 32'h5, 32'h5, 1'b0, 1, 0, 0, 32'h3018);
    step("alias", 32'h7018, 5, 32'h5, 32'h0, 1'b0, 1, 0, 0, 32'h3018);

    // Randomized resolves over a small, aliasing PC window
    for (int n = 0; n < 400; n++) begin
      pc = ($urandom & 32'hFFFF_0000) | (32'($urandom_range(0, 15)) << 2) | ($urandom & 32'h3);
      ppc = ($urandom_range(0, 1) == 1) ? pc : (32'h3000 | (32'($urandom_range(0, 15)) << 2));
      op = $urandom_range(0, 7);
      case ($urandom_range(0, 5))
        0: d1 = 32'h0;
        1: d1 = 32'h1;
        2: d1 = 32'hFFFF_FFFF;
        3: d1 = 32'h8000_0000;
        4: d1 = 32'h7FFF_FFFF;
        default: d1 = $urandom;
      endcase
      d2 = ($urandom_range(0, 1) == 1) ? d1 : $urandom;
      vld = ($urandom_range(0, 7) != 0);
      stl = ($urandom_range(0, 7) == 0);
      fl  = ($urandom_range(0, 7) == 0);
      prd = 1'($urandom_range(0, 1));
      step("rnd", pc, op, d1, d2, prd, vld, stl, fl, ppc);
    end

    // Asynchronous reset mid-cycle while an accepting request is presented
    res_valid = 1; res_pc = 32'h3020; res_op = 0; res_d1 = 32'h9; res_d2 = 32'h9;
    res_pred = 0; stall = 0; flush = 0; pred_pc = 32'h3020;
    #3;
    reset = 1'b0;
    model_reset();
    #1;
    check("async_valid", {31'd0, out_valid}, 32'd0);
    check("async_taken", {31'd0, out_taken}, 32'd0);
    check("async_mis", {31'd0, out_mispredict}, 32'd0);
    check_stats("async");
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle("post_rst", 32'h3020);
    check("post_rst_pht", {31'd0, pred_taken}, 32'd0);

`ifdef BRANCH_STATS_EN
    // Five resolves, two of them mispredicted
    step("st0", 32'h3040, 0, 32'h1, 32'h1, 1'b1, 1, 0, 0, 32'h3040);
    step("st1", 32'h3040, 0, 32'h1, 32'h2, 1'b1, 1, 0, 0, 32'h3040);
    step("st2", 32'h3044, 4, 32'h1, 32'h0, 1'b0, 1, 0, 0, 32'h3044);
    step("st3", 32'h3044, 5, 32'h1, 32'h0, 1'b0, 1, 0, 0, 32'h3044);
    step("st4", 32'h3048, 1, 32'h1, 32'h2, 1'b1, 1, 0, 0, 32'h3048);
    check("stat_br5", stat_branches, 32'd5);
    check("stat_mp2", stat_mispredicts, 32'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Parametrised successor to the ID-stage branch comparator of the pipelined MIPS core.
- Evaluates six compare modes on two operands and registers a taken/not-taken decision and a mispredict flag for the IF stage.
- Contains a bimodal pattern-history table (PHT) of 2-bit saturating counters.
- Predicts at IF (combinational read) and trains at resolve (sequential write).

Parameters:
- WIDTH, 32, operand width in bits (>=2).
- PHT_DEPTH, 64, number of PHT entries; power of two, >=2.
- IDX_LSB, 2, lowest PC bit used for the PHT index; index = pc[IDX_LSB +: log2(PHT_DEPTH)].

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- pred_pc  in  32  IF-stage PC to predict.
- pred_taken  out  1  PHT[idx(pred_pc)][1]; combinational.
- res_valid  in  1  a branch is presented for resolution this cycle.
- res_pc  in  32  PC of the resolving branch.
- res_op  in  3  compare mode: 0 EQ, 1 NE, 2 LEZ, 3 GTZ, 4 LTZ, 5 GEZ; 6 and 7 are illegal.
- res_d1  in  WIDTH  first operand (signed for the zero compares).
- res_d2  in  WIDTH  second operand (EQ/NE only).
- res_pred  in  1  prediction previously issued for this branch.
- stall  in  1  ID stall; the resolve request is held, not consumed.
- flush  in  1  discards the resolve request this cycle.
- out_valid  out  1  registered; a decision was accepted on the previous edge.
- out_taken  out  1  registered compare result.
- out_mispredict  out  1  registered; out_taken != res_pred.

Behaviour:
- Accept condition: accept = res_valid & !stall & !flush & (res_op <= 5).
- Compare (combinational, internal):
  - EQ: d1 == d2. NE: d1 != d2.
  - LEZ: $signed(d1) <= 0. GTZ: $signed(d1) > 0.
  - LTZ: $signed(d1) < 0. GEZ: $signed(d1) >= 0.
  - Illegal op: taken = 0, never accepted.
- Latency: 1 cycle. On an accepting edge:
  - out_valid = 1.
  - out_taken = cmp.
  - out_mispredict = cmp ^ res_pred.
- On a non-accepting edge: out_valid = 0. out_taken and out_mispredict hold their last value; consumers qualify them with out_valid.
- PHT update on an accepting edge, at entry idx(res_pc):
  - taken: saturating increment (3 stays 3).
  - not taken: saturating decrement (0 stays 0).
- Counter states: 0 strongly-NT, 1 weakly-NT, 2 weakly-T, 3 strongly-T.
- Same-index collision: when pred_pc and res_pc map to the same entry in the same cycle, pred_taken returns the pre-update value. The new value is visible from the next cycle.
- Priority:
  - flush overrides stall: no update, out_valid = 0.
  - stall with res_valid: no update, out_valid = 0. The request is re-presented later.
- Reset (asynchronous assert, synchronous-safe deassert):
  - Every PHT entry resets to 1 (weakly-NT).
  - out_valid, out_taken and out_mispredict reset to 0.
  - Counters (optional feature) reset to 0.
  - A reset during an accepting cycle discards that update.
- Index aliasing: PC bits above the index are ignored. Wrap-around of the index is intentional.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- When defined, adds two ports:
  - stat_branches out 32: count of accepted resolves.
  - stat_mispredicts out 32: count of accepted resolves with a mispredict.
- Both counters saturate at 32'hFFFF_FFFF. Both increment on the same edge the outputs register.
- When undefined: the ports and counters are absent, and the core behaviour is identical.

Decomposition:
- Shared package (branch_pkg): res_op encodings (BR_EQ..BR_GEZ), PHT reset constant (2'b01), counter state names.
- Sub-module branch_cmp: purely combinational WIDTH-parametrised compare (res_op, d1, d2 -> taken, illegal).
- The PHT and the output registers stay in branch_resolve_unit.

Test Plan:
- Reset, then pred_pc = 0x3000 -> pred_taken = 0 for all PHT_DEPTH indices; out_valid = 0.
- BEQ, d1 = d2 = 0x1234, res_pred = 0, pc = 0x3004 -> next cycle out_valid = 1, out_taken = 1, out_mispredict = 1. pred_pc = 0x3004 then reads 1 (counter 2).
- GTZ with d1 = 0x8000_0000, then LEZ with d1 = 0 -> out_taken = 0, then 1 (signed edge cases). GEZ with d1 = 0 -> taken.
- Three taken resolves at the same pc -> counter saturates at 3. Four not-taken resolves -> saturates at 0; pred_taken follows 1,1,1 then 1,0,0,0.
- res_valid with stall = 1 for 2 cycles, then stall = 0 -> exactly one update and a single out_valid pulse. flush = 1 together with stall = 1 -> no update. res_op = 6 -> out_valid = 0, PHT unchanged.
- With BRANCH_STATS_EN: 5 resolves including 2 mispredicts -> stat_branches = 5, stat_mispredicts = 2. Reset asserted mid-stream -> both read 0 immediately (asynchronous).
